// File: rtl/pspin_stdout_pkg.sv
// Shared constants for the PsPIN stdout collector: tagged word layout and
// the helper that assembles a word from its fields.
//
// Word layout (32 bits):
//   [31:24] cluster index
//   [23:16] core index, zero-extended
//   [15:8]  reserved, always 0
//   [7:0]   character
package pspin_stdout_pkg;

    localparam int WORD_W   = 32;
    localparam int FIELD_W  = 8;
    localparam int CHAR_W   = 8;
    localparam int CL_LSB   = 24;
    localparam int CORE_LSB = 16;
    localparam int PAD_LSB  = 8;
    localparam int CHAR_LSB = 0;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [FIELD_W-1:0] cl,
        input logic [FIELD_W-1:0] core,
        input logic [CHAR_W-1:0]  ch
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[CL_LSB+:FIELD_W]   = cl;
        w[CORE_LSB+:FIELD_W] = core;
        w[CHAR_LSB+:CHAR_W]  = ch;
        return w;
    endfunction

endpackage

// File: rtl/pspin_stdout_arb.sv
// Per-cluster 1-entry holding registers plus a round-robin grant.
// Exactly one occupied holding register is granted per cycle and its tagged
// word is presented on grant_word. A granted register is always released,
// whether or not the FIFO behind it keeps the word.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous clear of all holding registers
//   in_valid      per-cluster character valid
//   in_ready      per-cluster: register free or being granted this cycle
//   in_char       8 bits per cluster, cluster c at [8c+:8]
//   in_core       CORE_ID_W bits per cluster
//   grant_valid   a word is granted this cycle
//   grant_word    tagged word of the granted cluster
module pspin_stdout_arb
    import pspin_stdout_pkg::*;
#(
    parameter int NUM_CLUSTERS = 2,
    parameter int CORE_ID_W    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_CLUSTERS-1:0]           in_valid,
    output logic [NUM_CLUSTERS-1:0]           in_ready,
    input  logic [CHAR_W*NUM_CLUSTERS-1:0]    in_char,
    input  logic [CORE_ID_W*NUM_CLUSTERS-1:0] in_core,
    output logic                              grant_valid,
    output logic [WORD_W-1:0]                 grant_word
);

    localparam int IDX_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    logic [NUM_CLUSTERS-1:0] hold_valid;
    logic [CHAR_W-1:0]       hold_char [NUM_CLUSTERS];
    logic [CORE_ID_W-1:0]    hold_core [NUM_CLUSTERS];
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        rr_next;

    // Search starts at rr_ptr and wraps; first occupied register wins.
    always_comb begin
        logic [IDX_W:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_CLUSTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_CLUSTERS);
            end
            if (!grant_valid && hold_valid[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        logic [IDX_W:0] nxt;
        nxt = {1'b0, grant_idx} + (IDX_W+1)'(1);
        if (nxt >= (IDX_W+1)'(NUM_CLUSTERS)) begin
            nxt = '0;
        end
        rr_next = nxt[IDX_W-1:0];
    end

    always_comb begin
        grant_word = pack_word(FIELD_W'(grant_idx),
                               FIELD_W'(hold_core[grant_idx]),
                               hold_char[grant_idx]);
    end

    // A register being drained this cycle can be refilled in the same cycle,
    // so a lone streaming cluster sees no bubble.
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            in_ready[c] = !hold_valid[c] || (grant_valid && (grant_idx == IDX_W'(c)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                hold_char[c] <= '0;
                hold_core[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                if (flush) begin
                    hold_valid[c] <= 1'b0;
                end else if (in_valid[c] && in_ready[c]) begin
                    hold_valid[c] <= 1'b1;
                    hold_char[c]  <= in_char[CHAR_W*c+:CHAR_W];
                    hold_core[c]  <= in_core[CORE_ID_W*c+:CORE_ID_W];
                end else if (grant_valid && (grant_idx == IDX_W'(c))) begin
                    hold_valid[c] <= 1'b0;
                end
            end
            if (!flush && grant_valid) begin
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: rtl/pspin_stdout_fifo.sv
// Collects printf characters from the PsPIN clusters and buffers them as a
// first-word-fall-through stream of 32-bit tagged words for the host.
// Characters arriving while the FIFO is full are dropped and counted, so the
// clusters never stall on a slow host.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   per-cluster character handshake
//   in_char, in_core    per-cluster character and core index
//   flush               synchronous clear of FIFO and holding registers
//   stdout_rd_en        pop strobe from the register block
//   stdout_dout         head word (0 when empty)
//   stdout_data_valid   FIFO non-empty
//   drop_cnt            saturating count of characters dropped on full
//   fill_level          current occupancy
module pspin_stdout_fifo
    import pspin_stdout_pkg::*;
#(
    parameter int NUM_CLUSTERS = 2,
    parameter int CORE_ID_W    = 4,
    parameter int DEPTH        = 512
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLUSTERS-1:0]           in_valid,
    output logic [NUM_CLUSTERS-1:0]           in_ready,
    input  logic [CHAR_W*NUM_CLUSTERS-1:0]    in_char,
    input  logic [CORE_ID_W*NUM_CLUSTERS-1:0] in_core,
    input  logic                              flush,
    input  logic                              stdout_rd_en,
    output logic [WORD_W-1:0]                 stdout_dout,
    output logic                              stdout_data_valid,
    output logic [31:0]                       drop_cnt,
    output logic [$clog2(DEPTH):0]            fill_level
);

    localparam int AW = $clog2(DEPTH);

    logic              grant_valid;
    logic [WORD_W-1:0] grant_word;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              drop;

    pspin_stdout_arb #(
        .NUM_CLUSTERS (NUM_CLUSTERS),
        .CORE_ID_W    (CORE_ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_core     (in_core),
        .grant_valid (grant_valid),
        .grant_word  (grant_word)
    );

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // flush overrides both sides; a pop on empty is meaningless.
    assign pop      = stdout_rd_en && !empty && !flush;
    assign push_req = grant_valid && !flush;
    // A pop frees the head slot this cycle, so a full FIFO can still take the word.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= grant_word;
        end
    end

    assign stdout_data_valid = !empty;
    assign stdout_dout       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fill_level        = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
module tb_pspin_stdout_fifo;

    localparam int NC    = 2;
    localparam int CW    = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] core;
        logic       keep;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [8*NC-1:0]   in_char;
    logic [CW*NC-1:0]  in_core;
    logic              flush;
    logic              stdout_rd_en;
    logic [31:0]       stdout_dout;
    logic              stdout_data_valid;
    logic [31:0]       drop_cnt;
    logic [$clog2(DEPTH):0] fill_level;

    item_t       q0[$];
    item_t       q1[$];
    logic [31:0] sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic        s_valid;
    logic [31:0] s_dout;
    logic [31:0] s_fill;
    logic [31:0] s_drop;
    logic [1:0]  s_ready;

    always #5 clk = ~clk;

    pspin_stdout_fifo #(
        .NUM_CLUSTERS (NC),
        .CORE_ID_W    (CW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_char           (in_char),
        .in_core           (in_core),
        .flush             (flush),
        .stdout_rd_en      (stdout_rd_en),
        .stdout_dout       (stdout_dout),
        .stdout_data_valid (stdout_data_valid),
        .drop_cnt          (drop_cnt),
        .fill_level        (fill_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int cl, input logic [3:0] core, input logic [7:0] ch);
        logic [31:0] w;
        w = 32'h0;
        w[31:24] = cl[7:0];
        w[23:16] = {4'h0, core};
        w[7:0]   = ch;
        return w;
    endfunction

    task automatic sample();
        s_valid = stdout_data_valid;
        s_dout  = stdout_dout;
        s_fill  = 32'(fill_level);
        s_drop  = drop_cnt;
        s_ready = in_ready;
    endtask

    // One clock: drive at negedge, sample/score, then account handshakes at posedge.
    task automatic step(input logic rd, input logic fl);
        logic  hs0, hs1;
        item_t it;
        @(negedge clk);
        stdout_rd_en = rd;
        flush        = fl;
        in_valid[0]  = (q0.size() != 0);
        in_valid[1]  = (q1.size() != 0);
        if (q0.size() != 0) begin
            in_char[7:0] = q0[0].ch;
            in_core[3:0] = q0[0].core;
        end
        if (q1.size() != 0) begin
            in_char[15:8] = q1[0].ch;
            in_core[7:4]  = q1[0].core;
        end
        #1;
        sample();
        if (rd && s_valid && !fl) begin
            n_pops++;
            if (sb.size() == 0) begin
                check_eq("pop_unexpected", s_dout, 32'hDEAD_BEEF);
            end else begin
                check_eq("pop_dout", s_dout, sb.pop_front());
            end
        end
        hs0 = in_valid[0] && s_ready[0];
        hs1 = in_valid[1] && s_ready[1];
        @(posedge clk);
        if (hs0) begin
            it = q0.pop_front();
            if (it.keep) sb.push_back(exp_word(0, it.core, it.ch));
        end
        if (hs1) begin
            it = q1.pop_front();
            if (it.keep) sb.push_back(exp_word(1, it.core, it.ch));
        end
    endtask

    initial begin
        int g;
        int pops_before;
        rst_n        = 1'b0;
        in_valid     = '0;
        in_char      = '0;
        in_core      = '0;
        flush        = 1'b0;
        stdout_rd_en = 1'b0;
        #12;
        sample();
        check_eq("rst_valid", 32'(s_valid), 32'd0);
        check_eq("rst_dout", s_dout, 32'd0);
        check_eq("rst_fill", s_fill, 32'd0);
        check_eq("rst_drop", s_drop, 32'd0);
        check_eq("rst_ready", 32'(s_ready), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single character, latency and pop
        q1.push_back('{ch: 8'h41, core: 4'd3, keep: 1'b1});
        step(0, 0);
        step(0, 0);
        check_eq("t1_valid_grant_cycle", 32'(s_valid), 32'd0);
        step(0, 0);
        check_eq("t1_valid", 32'(s_valid), 32'd1);
        check_eq("t1_dout", s_dout, 32'h0103_0041);
        step(1, 0);
        step(0, 0);
        check_eq("t1_empty_after_pop", 32'(s_valid), 32'd0);
        check_eq("t1_fill_after_pop", s_fill, 32'd0);

        // 2: both clusters streaming, alternating order, one transfer per cycle
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{ch: 8'h61 + 8'(k), core: 4'(k), keep: 1'b1});
            q1.push_back('{ch: 8'h41 + 8'(k), core: 4'(k + 8), keep: 1'b1});
        end
        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 20) begin
            step(1, 0);
            g++;
        end
        check_eq("t2_input_cycles", 32'(g), 32'd7);
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            step(1, 0);
            g++;
        end
        check_eq("t2_drained", 32'(sb.size()), 32'd0);
        check_eq("t2_no_drops", s_drop, 32'd0);

        // 3: overfill with no pops
        for (int k = 0; k < 6; k++) begin
            q0.push_back('{ch: 8'h30 + 8'(k), core: 4'd1, keep: (k < 4)});
        end
        repeat (9) step(0, 0);
        check_eq("t3_fill_full", s_fill, 32'(DEPTH));
        check_eq("t3_drop_cnt", s_drop, 32'd2);
        check_eq("t3_valid", 32'(s_valid), 32'd1);

        // 4: full FIFO, push and pop in the same cycle
        q0.push_back('{ch: 8'h58, core: 4'd2, keep: 1'b1});
        step(0, 0);
        step(1, 0);
        step(0, 0);
        check_eq("t4_fill_still_full", s_fill, 32'(DEPTH));
        check_eq("t4_drop_unchanged", s_drop, 32'd2);
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            step(1, 0);
            g++;
        end
        check_eq("t4_drained", 32'(sb.size()), 32'd0);
        step(0, 0);
        check_eq("t4_empty", 32'(s_valid), 32'd0);

        // 5: pop on empty is ignored; pointers wrap without loss
        pops_before = n_pops;
        step(1, 0);
        check_eq("t5_empty_valid", 32'(s_valid), 32'd0);
        check_eq("t5_empty_dout", s_dout, 32'd0);
        step(0, 0);
        check_eq("t5_fill_unchanged", s_fill, 32'd0);
        check_eq("t5_no_pop_on_empty", 32'(n_pops - pops_before), 32'd0);
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            q1.push_back('{ch: 8'h60 + 8'(k), core: 4'(k), keep: 1'b1});
        end
        g = 0;
        while ((q1.size() != 0 || sb.size() != 0) && g < 60) begin
            step(1, 0);
            g++;
        end
        check_eq("t5_wrap_drained", 32'(sb.size() + q1.size()), 32'd0);
        check_eq("t5_wrap_pops", 32'(n_pops - pops_before), 32'(2 * DEPTH + 2));
        check_eq("t5_drop_unchanged", s_drop, 32'd2);

        // 6: flush with entries queued, inputs during flush discarded
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{ch: 8'h70 + 8'(k), core: 4'd7, keep: 1'b1});
        end
        g = 0;
        do begin
            step(0, 0);
            g++;
        end while (s_fill != 32'd3 && g < 10);
        check_eq("t6_fill_before_flush", s_fill, 32'd3);
        q0.push_back('{ch: 8'hEE, core: 4'd1, keep: 1'b0});
        q1.push_back('{ch: 8'hEF, core: 4'd2, keep: 1'b0});
        sb.delete();
        step(0, 1);
        step(0, 0);
        check_eq("t6_valid_after_flush", 32'(s_valid), 32'd0);
        check_eq("t6_fill_after_flush", s_fill, 32'd0);
        check_eq("t6_drop_kept", s_drop, 32'd2);
        check_eq("t6_inputs_taken", 32'(q0.size() + q1.size()), 32'd0);
        repeat (3) step(0, 0);
        check_eq("t6_stays_empty", s_fill, 32'd0);

        // reset mid-stream
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{ch: 8'h20 + 8'(k), core: 4'd4, keep: 1'b1});
        end
        repeat (3) step(0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = '0;
        #1;
        sample();
        check_eq("rst_mid_valid", 32'(s_valid), 32'd0);
        check_eq("rst_mid_dout", s_dout, 32'd0);
        check_eq("rst_mid_fill", s_fill, 32'd0);
        check_eq("rst_mid_drop", s_drop, 32'd0);
        check_eq("rst_mid_ready", 32'(s_ready), 32'd3);
        sb.delete();
        q0.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        pops_before = n_pops;
        q1.push_back('{ch: 8'h5A, core: 4'd5, keep: 1'b1});
        g = 0;
        while ((q1.size() != 0 || sb.size() != 0) && g < 10) begin
            step(1, 0);
            g++;
        end
        check_eq("post_rst_drained", 32'(sb.size()), 32'd0);
        check_eq("post_rst_one_pop", 32'(n_pops - pops_before), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
